pipe_stage_chain: RTL and testbench



---
 rtl/pipe_stage_chain_if.sv | 28 ++
 rtl/pipe_stage_chain.sv | 81 ++++++++
 tb/tb_pipe_stage_chain.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_if.sv
// Bundle of the control, payload and status signals around a pipe_stage_chain.
// Ports: freeze, flush_stages, in_valid and in_data go into the chain; stage_valid,
//        out_valid, out_data and occupancy come out of it. clk/rst stay outside the bundle.
// The master modport drives the chain; the slave modport belongs to the chain itself.
interface pipe_stage_chain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             freeze;
    logic [DEPTH-1:0] flush_stages;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [DEPTH-1:0] stage_valid;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] occupancy;

    modport master (
        output freeze, flush_stages, in_valid, in_data,
        input  stage_valid, out_valid, out_data, occupancy
    );

    modport slave (
        input  freeze, flush_stages, in_valid, in_data,
        output stage_valid, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH payload+valid stage registers with global freeze and per-stage flush.
// Latency: a word sampled at one edge is on out_data after DEPTH edges; each freeze cycle adds one.
// Backpressure: none downstream; freeze holds every unflushed stage and the inputs are not sampled.
// Ports: clk, rst (synchronous, active high); bus (slave side of pipe_stage_chain_if) carries
//        freeze, flush_stages, in_valid, in_data in and stage_valid, out_valid, out_data,
//        occupancy out. All outputs come straight from flops.
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stage_chain_if.slave  bus
);

    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_d;
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0]            valid_d;
    logic [CNT_W-1:0]            occupancy_q;
    logic [CNT_W-1:0]            occupancy_d;

    // What each stage would load on a normal advance: the stage before it,
    // with the input port acting as the stage in front of stage 0.
    logic [DEPTH-1:0][WIDTH-1:0] src_data;
    logic [DEPTH-1:0]            src_valid;

    generate
        if (DEPTH == 1) begin : g_single
            assign src_data  = bus.in_data;
            assign src_valid = bus.in_valid;
        end else begin : g_multi
            assign src_data  = {data_q[DEPTH-2:0], bus.in_data};
            assign src_valid = {valid_q[DEPTH-2:0], bus.in_valid};
        end
    endgenerate

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        occupancy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Flush beats freeze: a flushed stage is cleared even while the rest hold.
            if (bus.flush_stages[i]) begin
                data_d[i]  = '0;
                valid_d[i] = 1'b0;
            end else if (bus.freeze) begin
                data_d[i]  = data_q[i];
                valid_d[i] = valid_q[i];
            end else begin
                // Data moves whether or not it is valid; consumers qualify with valid.
                data_d[i]  = src_data[i];
                valid_d[i] = src_valid[i];
            end
        end
        // Count from the next-state bits so a flush and a shift in the same
        // cycle land on the exact population rather than a delta estimate.
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_d = occupancy_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            valid_q     <= '0;
            occupancy_q <= '0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign bus.stage_valid = valid_q;
    assign bus.out_valid   = valid_q[DEPTH-1];
    assign bus.out_data    = data_q[DEPTH-1];
    assign bus.occupancy   = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed vector table on a DEPTH=4 build,
// randomized run against a queue-based reference model, and a DEPTH=1 sequence.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit after the edge.
module tb_pipe_stage_chain;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int W1 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stage_chain_if #(.WIDTH(W),  .DEPTH(D)) bus4 ();
    pipe_stage_chain_if #(.WIDTH(W1), .DEPTH(1)) bus1 ();

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    pipe_stage_chain #(.WIDTH(W1), .DEPTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r;
        logic        f;
        logic [3:0]  fl;
        logic        iv;
        logic [31:0] id;
        logic [3:0]  sv;
        logic [31:0] od;
        logic [2:0]  occ;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic [3:0] fl, input logic iv,
                       input logic [31:0] id, input logic [3:0] sv, input logic [31:0] od,
                       input logic [2:0] occ);
        vec_t v;
        v.r = r; v.f = f; v.fl = fl; v.iv = iv; v.id = id;
        v.sv = sv; v.od = od; v.occ = occ;
        vecs.push_back(v);
    endtask

    task automatic drive4(input logic r, input logic f, input logic [3:0] fl, input logic iv,
                          input logic [31:0] id);
        rst               = r;
        bus4.freeze       = f;
        bus4.flush_stages = fl;
        bus4.in_valid     = iv;
        bus4.in_data      = id;
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic f, input logic fl, input logic iv, input logic [W1-1:0] id);
        rst               = 1'b0;
        bus1.freeze       = f;
        bus1.flush_stages = fl;
        bus1.in_valid     = iv;
        bus1.in_data      = id;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // The pipeline is a fixed-length queue of {valid,data} slots, index 0 nearest the input.
    // Advancing pushes the new word in at the front and drops the oldest one off the back.
    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
    } ent_t;

    ent_t mq[$];

    task automatic model_step(input logic r, input logic f, input logic [D-1:0] fl,
                              input logic iv, input logic [W-1:0] id);
        ent_t e;
        if (r) begin
            mq.delete();
            for (int i = 0; i < D; i++) mq.push_back('0);
        end else begin
            if (!f) begin
                e.v = iv;
                e.d = id;
                mq.push_front(e);
                void'(mq.pop_back());
            end
            for (int i = 0; i < D; i++) begin
                if (fl[i]) mq[i] = '0;
            end
        end
    endtask

    function automatic logic [D-1:0] model_sv();
        logic [D-1:0] s;
        for (int i = 0; i < D; i++) s[i] = mq[i].v;
        return s;
    endfunction

    function automatic int model_occ();
        int n = 0;
        foreach (mq[i]) if (mq[i].v) n++;
        return n;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst               = 1'b1;
        bus4.freeze       = 1'b0;
        bus4.flush_stages = '0;
        bus4.in_valid     = 1'b0;
        bus4.in_data      = '0;
        bus1.freeze       = 1'b0;
        bus1.flush_stages = '0;
        bus1.in_valid     = 1'b0;
        bus1.in_data      = '0;

        //   r  f  flush    iv  in_data      stage_valid od            occ
        // reset, inputs ignored
        add(1, 0, 4'b0000, 0, 32'h0,      4'b0000, 32'h0,      3'd0);
        add(1, 0, 4'b0000, 1, 32'hFF,     4'b0000, 32'h0,      3'd0);
        // fill / drain
        add(0, 0, 4'b0000, 1, 32'h11,     4'b0001, 32'h0,      3'd1);
        add(0, 0, 4'b0000, 1, 32'h22,     4'b0011, 32'h0,      3'd2);
        add(0, 0, 4'b0000, 1, 32'h33,     4'b0111, 32'h0,      3'd3);
        add(0, 0, 4'b0000, 1, 32'h44,     4'b1111, 32'h11,     3'd4);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b1110, 32'h22,     3'd3);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b1100, 32'h33,     3'd2);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b1000, 32'h44,     3'd1);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b0000, 32'h0,      3'd0);
        // fill, freeze three cycles, release: no loss, no duplicate
        add(0, 0, 4'b0000, 1, 32'hA0,     4'b0001, 32'h0,      3'd1);
        add(0, 0, 4'b0000, 1, 32'hA1,     4'b0011, 32'h0,      3'd2);
        add(0, 0, 4'b0000, 1, 32'hA2,     4'b0111, 32'h0,      3'd3);
        add(0, 0, 4'b0000, 1, 32'hA3,     4'b1111, 32'hA0,     3'd4);
        add(0, 1, 4'b0000, 1, 32'h99,     4'b1111, 32'hA0,     3'd4);
        add(0, 1, 4'b0000, 1, 32'h99,     4'b1111, 32'hA0,     3'd4);
        add(0, 1, 4'b0000, 1, 32'h99,     4'b1111, 32'hA0,     3'd4);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b1110, 32'hA1,     3'd3);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b1100, 32'hA2,     3'd2);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b1000, 32'hA3,     3'd1);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b0000, 32'h0,      3'd0);
        // branch-style flush of stages 0,1 while shifting
        add(0, 0, 4'b0000, 1, 32'hB0,     4'b0001, 32'h0,      3'd1);
        add(0, 0, 4'b0000, 1, 32'hB1,     4'b0011, 32'h0,      3'd2);
        add(0, 0, 4'b0000, 1, 32'hB2,     4'b0111, 32'h0,      3'd3);
        add(0, 0, 4'b0000, 1, 32'hB3,     4'b1111, 32'hB0,     3'd4);
        add(0, 0, 4'b0011, 1, 32'hBEEF,   4'b1100, 32'hB1,     3'd2);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b1000, 32'hB2,     3'd1);
        // flush over freeze on the last stage
        add(0, 0, 4'b0000, 1, 32'hC0,     4'b0001, 32'h0,      3'd1);
        add(0, 0, 4'b0000, 1, 32'hC1,     4'b0011, 32'h0,      3'd2);
        add(0, 0, 4'b0000, 1, 32'hC2,     4'b0111, 32'h0,      3'd3);
        add(0, 0, 4'b0000, 1, 32'hC3,     4'b1111, 32'hC0,     3'd4);
        add(0, 1, 4'b1000, 1, 32'h77,     4'b0111, 32'h0,      3'd3);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b1110, 32'hC1,     3'd3);
        // refill, reset mid-operation, then 0x55 goes end to end
        add(0, 0, 4'b0000, 1, 32'hD0,     4'b1101, 32'hC2,     3'd3);
        add(0, 0, 4'b0000, 1, 32'hD1,     4'b1011, 32'hC3,     3'd3);
        add(0, 0, 4'b0000, 1, 32'hD2,     4'b0111, 32'h0,      3'd3);
        add(0, 0, 4'b0000, 1, 32'hD3,     4'b1111, 32'hD0,     3'd4);
        add(1, 0, 4'b0000, 1, 32'h66,     4'b0000, 32'h0,      3'd0);
        add(0, 0, 4'b0000, 1, 32'h55,     4'b0001, 32'h0,      3'd1);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b0010, 32'h0,      3'd1);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b0100, 32'h0,      3'd1);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b1000, 32'h55,     3'd1);
        add(0, 0, 4'b0000, 0, 32'h0,      4'b0000, 32'h0,      3'd0);

        for (int n = 0; n < vecs.size(); n++) begin
            vec_t v;
            v = vecs[n];
            drive4(v.r, v.f, v.fl, v.iv, v.id);
            chk($sformatf("vec%0d stage_valid", n), 64'(bus4.stage_valid), 64'(v.sv));
            chk($sformatf("vec%0d out_valid",   n), 64'(bus4.out_valid),   64'(v.sv[3]));
            chk($sformatf("vec%0d out_data",    n), 64'(bus4.out_data),    64'(v.od));
            chk($sformatf("vec%0d occupancy",   n), 64'(bus4.occupancy),   64'(v.occ));
        end

        // ---------------- randomized run against the model ----------------
        drive4(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0);
        model_step(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0);
        for (int c = 0; c < 1500; c++) begin
            logic        r, f, iv;
            logic [3:0]  fl;
            logic [31:0] id;
            r  = ($urandom_range(0, 49) == 0);
            f  = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < D; b++) fl[b] = ($urandom_range(0, 7) == 0);
            iv = 1'($urandom_range(0, 1));
            id = $urandom;
            drive4(r, f, fl, iv, id);
            model_step(r, f, fl, iv, id);
            chk($sformatf("rnd%0d stage_valid", c), 64'(bus4.stage_valid), 64'(model_sv()));
            chk($sformatf("rnd%0d out_valid",   c), 64'(bus4.out_valid),   64'(mq[D-1].v));
            chk($sformatf("rnd%0d out_data",    c), 64'(bus4.out_data),    64'(mq[D-1].d));
            chk($sformatf("rnd%0d occupancy",   c), 64'(bus4.occupancy),   64'(model_occ()));
        end

        // ---------------- DEPTH=1 build ----------------
        drive4(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0);
        chk("d1 reset out_valid", 64'(bus1.out_valid), 64'd0);
        chk("d1 reset occupancy", 64'(bus1.occupancy), 64'd0);
        drive1(1'b0, 1'b0, 1'b1, 4'h7);
        chk("d1 load out_data",    64'(bus1.out_data),    64'h7);
        chk("d1 load out_valid",   64'(bus1.out_valid),   64'd1);
        chk("d1 load stage_valid", 64'(bus1.stage_valid), 64'd1);
        chk("d1 load occupancy",   64'(bus1.occupancy),   64'd1);
        drive1(1'b0, 1'b1, 1'b1, 4'h5);
        chk("d1 flush out_valid", 64'(bus1.out_valid), 64'd0);
        chk("d1 flush out_data",  64'(bus1.out_data),  64'h0);
        chk("d1 flush occupancy", 64'(bus1.occupancy), 64'd0);
        drive1(1'b0, 1'b0, 1'b1, 4'h5);
        chk("d1 reload out_data", 64'(bus1.out_data), 64'h5);
        drive1(1'b1, 1'b0, 1'b1, 4'h9);
        chk("d1 freeze out_data",  64'(bus1.out_data),  64'h5);
        chk("d1 freeze occupancy", 64'(bus1.occupancy), 64'd1);
        drive1(1'b1, 1'b1, 1'b1, 4'h9);
        chk("d1 flush+freeze out_valid", 64'(bus1.out_valid), 64'd0);
        chk("d1 flush+freeze out_data",  64'(bus1.out_data),  64'h0);
        drive1(1'b0, 1'b0, 1'b1, 4'h9);
        chk("d1 release out_data", 64'(bus1.out_data), 64'h9);
        drive1(1'b0, 1'b0, 1'b0, 4'h3);
        chk("d1 invalid out_valid", 64'(bus1.out_valid), 64'd0);
        chk("d1 invalid out_data",  64'(bus1.out_data),  64'h3);
        chk("d1 invalid occupancy", 64'(bus1.occupancy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
